// File: rtl/dtlb_refill_ctrl_if.sv
// Signal bundle between the DTLB refill controller, the lookup ports,
// the page walker, the invalidate requester and the TLB write port.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

interface dtlb_refill_ctrl_if #(
  parameter int DATA_W = `dtlbData_width
);
  logic [5:0]        miss_en;
  logic [5:0][51:0]  miss_addr;

  logic              walk_req;
  logic [50:0]       walk_addr;
  logic              walk_rdy;
  logic              walk_done;
  logic              walk_fault;
  logic [DATA_W-1:0] walk_data0;
  logic [DATA_W-1:0] walk_data1;
  logic [DATA_W-1:0] walk_data2;

  logic              invl_req;
  logic [50:0]       invl_addr;
  logic [2:0]        invl_way;
  logic              invl_ack;

  logic [50:0]       tlb_write_addr;
  logic [DATA_W-1:0] tlb_write_data0;
  logic [DATA_W-1:0] tlb_write_data1;
  logic [DATA_W-1:0] tlb_write_data2;
  logic              tlb_write_wen;
  logic              tlb_write_xstant;
  logic              tlb_write_invl;
  logic              tlb_force_way_en;
  logic [2:0]        tlb_force_way;

  logic              replay;
  logic [50:0]       replay_addr;
  logic              fault;
  logic [50:0]       fault_addr;
  logic              queue_full;
  logic              busy;

  modport master (
    input  miss_en, miss_addr,
    input  walk_rdy, walk_done, walk_fault, walk_data0, walk_data1, walk_data2,
    input  invl_req, invl_addr, invl_way,
    output walk_req, walk_addr, invl_ack,
    output tlb_write_addr, tlb_write_data0, tlb_write_data1, tlb_write_data2,
    output tlb_write_wen, tlb_write_xstant, tlb_write_invl,
    output tlb_force_way_en, tlb_force_way,
    output replay, replay_addr, fault, fault_addr, queue_full, busy
  );

  modport slave (
    output miss_en, miss_addr,
    output walk_rdy, walk_done, walk_fault, walk_data0, walk_data1, walk_data2,
    output invl_req, invl_addr, invl_way,
    input  walk_req, walk_addr, invl_ack,
    input  tlb_write_addr, tlb_write_data0, tlb_write_data1, tlb_write_data2,
    input  tlb_write_wen, tlb_write_xstant, tlb_write_invl,
    input  tlb_force_way_en, tlb_force_way,
    input  replay, replay_addr, fault, fault_addr, queue_full, busy
  );
endinterface

// File: rtl/dtlb_refill_ctrl.sv
// DTLB miss queue (4-entry, dedup, round-robin over 6 ports), single page-walk
// sequencer and TLB write-port driver for refills and targeted invalidations.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module dtlb_refill_ctrl #(
  parameter int DATA_W = `dtlbData_width,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  dtlb_refill_ctrl_if.master bus
);

  typedef enum logic [2:0] {RST_WAIT, IDLE, REQ, WAIT, FILL, INVL} state_e;

  state_e            state_q;
  logic [4:0]        rst_cnt_q;

  logic [50:0]       q_addr_q [4];
  logic [3:0]        q_vld_q;
  logic [1:0]        head_q;
  logic [1:0]        tail_q;
  logic [2:0]        count_q;
  logic [2:0]        count_d;
  logic [2:0]        rr_ptr_q;

  logic              walk_req_q;
  logic [50:0]       walk_addr_q;
  logic [50:0]       wr_addr_q;
  logic [DATA_W-1:0] wr_data0_q;
  logic [DATA_W-1:0] wr_data1_q;
  logic [DATA_W-1:0] wr_data2_q;
  logic              wr_wen_q;
  logic              wr_xstant_q;
  logic              wr_invl_q;
  logic              force_en_q;
  logic [2:0]        force_way_q;
  logic              replay_q;
  logic [50:0]       replay_addr_q;
  logic              fault_q;
  logic [50:0]       fault_addr_q;
  logic              invl_ack_q;

  logic [5:0]        elig;
  logic              found;
  logic [2:0]        win;
  logic              push;
  logic              pop;
  logic [50:0]       head_addr;
  logic              unused_lsb;

  assign head_addr = q_addr_q[head_q];

  // The half-of-pair select bit plays no part in queueing or walking.
  assign unused_lsb = ^{bus.miss_addr[0][0], bus.miss_addr[1][0], bus.miss_addr[2][0],
                        bus.miss_addr[3][0], bus.miss_addr[4][0], bus.miss_addr[5][0]};

  // A port is eligible if it missed and its pair is not already queued,
  // including the head entry that is currently being walked.
  always_comb begin
    elig = '0;
    for (int p = 0; p < 6; p++) begin
      elig[p[2:0]] = bus.miss_en[p[2:0]];
      for (int e = 0; e < 4; e++) begin
        if (q_vld_q[e[1:0]] && (q_addr_q[e[1:0]] == bus.miss_addr[p[2:0]][51:1])) begin
          elig[p[2:0]] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    int idx;
    found = 1'b0;
    win   = 3'd0;
    idx   = 0;
    for (int i = 0; i < 6; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= 6) begin
        idx = idx - 6;
      end
      if (!found && elig[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  assign push    = found && (state_q != RST_WAIT) && (count_q < 3'(QDEPTH));
  assign pop     = (state_q == FILL);
  assign count_d = count_q + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (pop) begin
        q_vld_q[head_q] <= 1'b0;
        head_q          <= head_q + 2'd1;
      end
      if (push) begin
        q_vld_q[tail_q]  <= 1'b1;
        q_addr_q[tail_q] <= bus.miss_addr[win][51:1];
        tail_q           <= tail_q + 2'd1;
        rr_ptr_q         <= (win == 3'd5) ? 3'd0 : win + 3'd1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_WAIT;
      rst_cnt_q     <= '0;
      walk_req_q    <= 1'b0;
      walk_addr_q   <= '0;
      wr_addr_q     <= '0;
      wr_data0_q    <= '0;
      wr_data1_q    <= '0;
      wr_data2_q    <= '0;
      wr_wen_q      <= 1'b0;
      wr_xstant_q   <= 1'b0;
      wr_invl_q     <= 1'b0;
      force_en_q    <= 1'b0;
      force_way_q   <= '0;
      replay_q      <= 1'b0;
      replay_addr_q <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      invl_ack_q    <= 1'b0;
    end else begin
      // Write-port and pulse outputs are zero unless this edge issues one.
      wr_addr_q     <= '0;
      wr_data0_q    <= '0;
      wr_data1_q    <= '0;
      wr_data2_q    <= '0;
      wr_wen_q      <= 1'b0;
      wr_xstant_q   <= 1'b0;
      wr_invl_q     <= 1'b0;
      force_en_q    <= 1'b0;
      force_way_q   <= '0;
      replay_q      <= 1'b0;
      replay_addr_q <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      invl_ack_q    <= 1'b0;

      case (state_q)
        RST_WAIT: begin
          if (rst_cnt_q == 5'd16) begin
            state_q <= IDLE;
          end else begin
            rst_cnt_q <= rst_cnt_q + 5'd1;
          end
        end
        IDLE: begin
          if (bus.invl_req) begin
            state_q     <= INVL;
            wr_wen_q    <= 1'b1;
            wr_xstant_q <= 1'b1;
            wr_invl_q   <= 1'b1;
            force_en_q  <= 1'b1;
            force_way_q <= bus.invl_way;
            wr_addr_q   <= bus.invl_addr;
            invl_ack_q  <= 1'b1;
          end else if (count_q != 3'd0) begin
            state_q     <= REQ;
            walk_req_q  <= 1'b1;
            walk_addr_q <= head_addr;
          end
        end
        REQ: begin
          if (bus.walk_rdy) begin
            state_q     <= WAIT;
            walk_req_q  <= 1'b0;
            walk_addr_q <= '0;
          end
        end
        WAIT: begin
          // The walk result is captured straight into the write-port registers,
          // so it is on the TLB write port throughout the FILL cycle.
          if (bus.walk_done) begin
            state_q <= FILL;
            if (!bus.walk_fault) begin
              wr_wen_q      <= 1'b1;
              wr_addr_q     <= head_addr;
              wr_data0_q    <= bus.walk_data0;
              wr_data1_q    <= bus.walk_data1;
              wr_data2_q    <= bus.walk_data2;
              replay_q      <= 1'b1;
              replay_addr_q <= head_addr;
            end else begin
              fault_q      <= 1'b1;
              fault_addr_q <= head_addr;
            end
          end
        end
        FILL:    state_q <= IDLE;
        INVL:    state_q <= IDLE;
        default: state_q <= RST_WAIT;
      endcase
    end
  end

  assign bus.walk_req         = walk_req_q;
  assign bus.walk_addr        = walk_addr_q;
  assign bus.invl_ack         = invl_ack_q;
  assign bus.tlb_write_addr   = wr_addr_q;
  assign bus.tlb_write_data0  = wr_data0_q;
  assign bus.tlb_write_data1  = wr_data1_q;
  assign bus.tlb_write_data2  = wr_data2_q;
  assign bus.tlb_write_wen    = wr_wen_q;
  assign bus.tlb_write_xstant = wr_xstant_q;
  assign bus.tlb_write_invl   = wr_invl_q;
  assign bus.tlb_force_way_en = force_en_q;
  assign bus.tlb_force_way    = force_way_q;
  assign bus.replay           = replay_q;
  assign bus.replay_addr      = replay_addr_q;
  assign bus.fault            = fault_q;
  assign bus.fault_addr       = fault_addr_q;
  assign bus.queue_full       = (count_q == 3'(QDEPTH));
  assign bus.busy             = (state_q != IDLE) || (count_q != 3'd0);

endmodule

// File: tb/tb_dtlb_refill_ctrl.sv
// Directed bench for dtlb_refill_ctrl: reset wait, refill, round-robin/full,
// dedup, invalidate ordering and fault handling.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module tb_dtlb_refill_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  dtlb_refill_ctrl_if bus ();

  dtlb_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts in REQ; hands the walk over, returns the result, checks the FILL
  // cycle and comes back in IDLE right after the pop.
  task automatic do_walk(input logic [50:0] a, input logic flt, input logic [63:0] d);
    chk("walk_req_up", bus.walk_req, 1'b1);
    chk("walk_addr", bus.walk_addr, a);
    bus.walk_rdy = 1'b1;
    step();
    bus.walk_rdy = 1'b0;
    chk("walk_req_drop", bus.walk_req, 1'b0);
    bus.walk_done  = 1'b1;
    bus.walk_fault = flt;
    bus.walk_data0 = d;
    bus.walk_data1 = d + 64'd1;
    bus.walk_data2 = d + 64'd2;
    step();
    bus.walk_done  = 1'b0;
    bus.walk_fault = 1'b0;
    chk("fill_wen", bus.tlb_write_wen, !flt);
    chk("fill_replay", bus.replay, !flt);
    chk("fill_fault", bus.fault, flt);
    if (!flt) begin
      chk("fill_addr", bus.tlb_write_addr, a);
      chk("fill_data0", bus.tlb_write_data0, d);
      chk("fill_data2", bus.tlb_write_data2, d + 64'd2);
      chk("replay_addr", bus.replay_addr, a);
      chk("fill_xstant", bus.tlb_write_xstant, 1'b0);
    end else begin
      chk("fault_addr", bus.fault_addr, a);
    end
    step();
    chk("post_fill_wen", bus.tlb_write_wen, 1'b0);
    chk("post_fill_pulses", {bus.replay, bus.fault}, 2'b00);
  endtask

  // Two reset cycles, then the 17-cycle self-init window; optionally a stray
  // walk_done right after reset, which must not produce a write.
  task automatic do_reset(input logic stray_done);
    rst = 1'b1;
    step();
    step();
    chk("rst_walk_req", bus.walk_req, 1'b0);
    chk("rst_wen", bus.tlb_write_wen, 1'b0);
    chk("rst_pulses", {bus.replay, bus.fault, bus.invl_ack}, 3'b000);
    chk("rst_wr_addr", bus.tlb_write_addr, 51'd0);
    chk("rst_queue_full", bus.queue_full, 1'b0);
    chk("rst_busy", bus.busy, 1'b1);
    rst = 1'b0;
    bus.walk_done = stray_done;
    for (int i = 0; i < 16; i++) begin
      step();
      bus.walk_done = 1'b0;
      chk("rstwait_busy", bus.busy, 1'b1);
      chk("rstwait_walk_req", bus.walk_req, 1'b0);
      chk("rstwait_replay", bus.replay, 1'b0);
    end
    step();
    chk("rstwait_done_idle", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.miss_en    = '0;
    bus.miss_addr  = '0;
    bus.walk_rdy   = 1'b0;
    bus.walk_done  = 1'b0;
    bus.walk_fault = 1'b0;
    bus.walk_data0 = '0;
    bus.walk_data1 = '0;
    bus.walk_data2 = '0;
    bus.invl_req   = 1'b0;
    bus.invl_addr  = '0;
    bus.invl_way   = '0;

    // Reset with port 0 missing 0x10 throughout.
    bus.miss_en      = 6'b000001;
    bus.miss_addr[0] = 52'h10;
    do_reset(1'b0);
    step();
    chk("first_enq_busy", bus.busy, 1'b1);
    chk("first_enq_no_req", bus.walk_req, 1'b0);
    step();
    do_walk(51'h8, 1'b0, 64'h0123_4567_89AB_0000);
    bus.miss_en = '0;
    chk("p1_idle", bus.busy, 1'b0);

    // Single refill from port 2 with a one-cycle late walk_rdy.
    bus.miss_en      = 6'b000100;
    bus.miss_addr[2] = 52'h1235;
    step();
    bus.miss_en = '0;
    step();
    chk("stall_req0", bus.walk_req, 1'b1);
    chk("stall_addr0", bus.walk_addr, 51'h91A);
    step();
    chk("stall_req1", bus.walk_req, 1'b1);
    chk("stall_addr1", bus.walk_addr, 51'h91A);
    bus.walk_rdy = 1'b1;
    step();
    bus.walk_rdy = 1'b0;
    chk("wait_req_low", bus.walk_req, 1'b0);
    step();
    chk("wait_no_wen", bus.tlb_write_wen, 1'b0);
    bus.walk_done  = 1'b1;
    bus.walk_data0 = 64'hAAAA_AAAA_0000_000A;
    bus.walk_data1 = 64'hBBBB_BBBB_0000_000B;
    bus.walk_data2 = 64'hCCCC_CCCC_0000_000C;
    step();
    bus.walk_done = 1'b0;
    chk("sr_wen", bus.tlb_write_wen, 1'b1);
    chk("sr_ctl", {bus.tlb_write_xstant, bus.tlb_write_invl, bus.tlb_force_way_en}, 3'b000);
    chk("sr_addr", bus.tlb_write_addr, 51'h91A);
    chk("sr_data0", bus.tlb_write_data0, 64'hAAAA_AAAA_0000_000A);
    chk("sr_data1", bus.tlb_write_data1, 64'hBBBB_BBBB_0000_000B);
    chk("sr_data2", bus.tlb_write_data2, 64'hCCCC_CCCC_0000_000C);
    chk("sr_replay", bus.replay, 1'b1);
    chk("sr_replay_addr", bus.replay_addr, 51'h91A);
    step();
    chk("sr_after_wen", bus.tlb_write_wen, 1'b0);
    chk("sr_after_replay", bus.replay, 1'b0);
    chk("sr_idle", bus.busy, 1'b0);

    // Walk in flight from port 5, then reset abandons it; all six ports miss.
    bus.miss_en      = 6'b100000;
    bus.miss_addr[5] = 52'h400;
    step();
    bus.miss_en = '0;
    step();
    bus.walk_rdy = 1'b1;
    step();
    bus.walk_rdy = 1'b0;
    for (int p = 0; p < 6; p++) begin
      bus.miss_addr[p] = 52'h100 * 52'(p + 1);
    end
    bus.miss_en = 6'b111111;
    do_reset(1'b1);

    step();
    chk("rr_fill1_qf", bus.queue_full, 1'b0);
    step();
    chk("rr_fill2_req", bus.walk_req, 1'b1);
    chk("rr_fill2_qf", bus.queue_full, 1'b0);
    step();
    chk("rr_fill3_qf", bus.queue_full, 1'b0);
    step();
    chk("rr_full", bus.queue_full, 1'b1);
    step();
    chk("rr_full_hold", bus.queue_full, 1'b1);
    do_walk(51'h80, 1'b0, 64'h1000);
    chk("rr_after_pop_qf", bus.queue_full, 1'b0);
    step();
    chk("rr_p4_full", bus.queue_full, 1'b1);
    do_walk(51'h100, 1'b0, 64'h2000);
    step();
    chk("rr_p5_full", bus.queue_full, 1'b1);
    do_walk(51'h180, 1'b0, 64'h3000);
    bus.miss_en = '0;
    step();
    chk("rr_drain_qf", bus.queue_full, 1'b0);
    do_walk(51'h200, 1'b0, 64'h4000);
    step();
    do_walk(51'h280, 1'b0, 64'h5000);
    step();
    do_walk(51'h300, 1'b0, 64'h6000);
    step();
    chk("rr_empty", bus.busy, 1'b0);

    // Dedup: ports 1 and 4 share a pair, misses held through the walk.
    bus.miss_addr    = '0;
    bus.miss_addr[1] = 52'h20;
    bus.miss_addr[4] = 52'h21;
    bus.miss_en      = 6'b010010;
    step();
    chk("dd_busy", bus.busy, 1'b1);
    step();
    do_walk(51'h10, 1'b0, 64'h7000);
    bus.miss_en = '0;
    chk("dd_single_entry", bus.busy, 1'b0);
    step();
    chk("dd_no_req", bus.walk_req, 1'b0);
    chk("dd_still_idle", bus.busy, 1'b0);

    // Invalidate raised during WAIT is served after the fill.
    bus.miss_en      = 6'b000001;
    bus.miss_addr[0] = 52'h200;
    step();
    bus.miss_en = '0;
    step();
    chk("iv_req", bus.walk_req, 1'b1);
    bus.walk_rdy = 1'b1;
    step();
    bus.walk_rdy  = 1'b0;
    bus.invl_req  = 1'b1;
    bus.invl_addr = 51'h55;
    bus.invl_way  = 3'd6;
    step();
    chk("iv_wait_ack", bus.invl_ack, 1'b0);
    chk("iv_wait_wen", bus.tlb_write_wen, 1'b0);
    bus.walk_done  = 1'b1;
    bus.walk_data0 = 64'h8000;
    step();
    bus.walk_done = 1'b0;
    chk("iv_fill_wen", bus.tlb_write_wen, 1'b1);
    chk("iv_fill_xstant", bus.tlb_write_xstant, 1'b0);
    chk("iv_fill_addr", bus.tlb_write_addr, 51'h100);
    chk("iv_fill_ack", bus.invl_ack, 1'b0);
    step();
    chk("iv_gap_wen", bus.tlb_write_wen, 1'b0);
    chk("iv_gap_ack", bus.invl_ack, 1'b0);
    step();
    chk("iv_wen", bus.tlb_write_wen, 1'b1);
    chk("iv_ctl", {bus.tlb_write_xstant, bus.tlb_write_invl, bus.tlb_force_way_en}, 3'b111);
    chk("iv_way", bus.tlb_force_way, 3'd6);
    chk("iv_addr", bus.tlb_write_addr, 51'h55);
    chk("iv_ack", bus.invl_ack, 1'b1);
    chk("iv_replay", bus.replay, 1'b0);
    bus.invl_req = 1'b0;
    step();
    chk("iv_after_ack", bus.invl_ack, 1'b0);
    chk("iv_after_wen", bus.tlb_write_wen, 1'b0);
    chk("iv_idle", bus.busy, 1'b0);

    // Faulting walk for pair 0x77.
    bus.miss_en      = 6'b001000;
    bus.miss_addr[3] = 52'hEE;
    step();
    bus.miss_en = '0;
    step();
    do_walk(51'h77, 1'b1, 64'h9000);
    chk("ft_popped", bus.busy, 1'b0);
    chk("ft_no_replay", bus.replay, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
